// File: rtl/leds_show_pkg.sv
// Shared constants and width helper for the leds_show push-button/LED block.
package leds_show_pkg;

  localparam int DEBOUNCE_CYCLES_DEF   = 4;
  localparam int BLINK_HALF_PERIOD_DEF = 8;

  // Bits needed to hold a counter with n_states distinct values (minimum 1).
  function automatic int cnt_width(input int n_states);
    return (n_states <= 2) ? 1 : $clog2(n_states);
  endfunction

endpackage

// File: rtl/leds_show_debounce.sv
// Two-flop synchronizer plus mismatch-run debouncer for the raw push-button level.
module leds_show_debounce
  import leds_show_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_button,
  output logic o_db,
  output logic o_db_rise
);

  localparam int              CW       = cnt_width(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_db;
  logic [CW-1:0] r_cnt;
  logic          w_accept;

  assign w_accept = (r_sync2 != r_db) && (r_cnt == CNT_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_db    <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_button;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_db) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_db  <= r_sync2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_db = r_db;
  // High in the cycle before db goes 0->1, so blink phase can rise on the same edge.
  assign o_db_rise = w_accept & r_sync2;

endmodule

// File: rtl/leds_show.sv
// Button-to-LED top: debounced level drives led; LEDS_SHOW_BLINK_EN adds a blink
// while the button is held.
module leds_show
  import leds_show_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = DEBOUNCE_CYCLES_DEF,
  parameter int BLINK_HALF_PERIOD = BLINK_HALF_PERIOD_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pushButton,
  output logic led
);

  logic w_db;
  logic w_db_rise;

  leds_show_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_button (pushButton),
    .o_db     (w_db),
    .o_db_rise(w_db_rise)
  );

`ifdef LEDS_SHOW_BLINK_EN
  localparam int            BW        = cnt_width(BLINK_HALF_PERIOD);
  localparam logic [BW-1:0] BCNT_LAST = BW'(BLINK_HALF_PERIOD - 1);

  logic          r_phase;
  logic [BW-1:0] r_bcnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase <= 1'b0;
      r_bcnt  <= '0;
    end else if (!w_db) begin
      r_phase <= w_db_rise;
      r_bcnt  <= '0;
    end else if (r_bcnt == BCNT_LAST) begin
      r_phase <= ~r_phase;
      r_bcnt  <= '0;
    end else begin
      r_bcnt <= r_bcnt + 1'b1;
    end
  end

  assign led = w_db & r_phase;
`else
  logic w_unused_blink;
  assign w_unused_blink = w_db_rise | (BLINK_HALF_PERIOD < 1);
  assign led = w_db;
`endif

endmodule

// File: tb/tb_leds_show.sv
// Directed bench for leds_show: reset, latency, glitch rejection, toggling, blink.
module tb_leds_show;

  logic clk = 1'b0;
  logic rst_n;
  logic pushButton;
  logic led;
  logic led1;

  always #5 clk = ~clk;

  leds_show dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pushButton(pushButton),
    .led       (led)
  );

  leds_show #(.DEBOUNCE_CYCLES(1)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .pushButton(pushButton),
    .led       (led1)
  );

  int n_checks = 0;
  int n_fails  = 0;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic hist [0:511];
  int   runs [8] = '{5, 6, 4, 7, 4, 5, 30, 10};

  initial begin
    int   n;
    int   k;
    logic val;
    logic db_m;
    logic exp_led;

    // reset with an undriven button, then a driven 0
    rst_n      = 1'b0;
    pushButton = 1'bx;
    repeat (3) tick();
    chk("rst_x_led", led, 1'b0);
    chk("rst_x_led1", led1, 1'b0);
    pushButton = 1'b0;
    repeat (2) tick();
    chk("rst_0_led", led, 1'b0);
    rst_n = 1'b1;
    repeat (3) tick();
    chk("post_rst_led", led, 1'b0);

    // press: default rises after 6th edge, DEBOUNCE_CYCLES=1 after 3rd
    pushButton = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk("press_led", led, i >= 6);
      chk("press_led1", led1, i >= 3);
    end
    pushButton = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk("release_led", led, i < 6);
      chk("release_led1", led1, i < 3);
    end

    // 2-clock glitch is discarded
    pushButton = 1'b1;
    repeat (2) begin
      tick();
      chk("glitch_hi_led", led, 1'b0);
    end
    pushButton = 1'b0;
    repeat (8) begin
      tick();
      chk("glitch_lo_led", led, 1'b0);
    end

    // bounce 1,0 then steady press: rise 6 edges after final transition
    pushButton = 1'b1;
    tick();
    chk("bounce_a_led", led, 1'b0);
    pushButton = 1'b0;
    tick();
    chk("bounce_b_led", led, 1'b0);
    pushButton = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk("bounce_press_led", led, i >= 6);
    end
    pushButton = 1'b0;
    repeat (8) tick();
    chk("bounce_release_led", led, 1'b0);

    // reset mid-count: led cleared asynchronously, count restarts after release
    pushButton = 1'b1;
    repeat (4) tick();
    chk("midcnt_pre_led", led, 1'b0);
    chk("midcnt_pre_led1", led1, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("midcnt_async_led1", led1, 1'b0);
    chk("midcnt_async_led", led, 1'b0);
    repeat (2) tick();
    rst_n = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk("midcnt_restart_led", led, i >= 6);
      chk("midcnt_restart_led1", led1, i >= 3);
    end

    // toggle sequence against a 5-edge delay-line model (plus blink phase if enabled)
    pushButton = 1'b0;
    repeat (10) tick();
    for (int i = 0; i < 10; i++) hist[i] = 1'b0;
    n   = 10;
    k   = 0;
    val = 1'b1;
    foreach (runs[r]) begin
      for (int j = 0; j < runs[r]; j++) begin
        pushButton = val;
        hist[n]    = val;
        tick();
        db_m = hist[n-5];
        k    = db_m ? k + 1 : 0;
        exp_led = db_m;
`ifdef LEDS_SHOW_BLINK_EN
        if (db_m && (((k - 1) / 8) % 2 != 0)) exp_led = 1'b0;
`endif
        chk("toggle_led", led, exp_led);
        n++;
      end
      val = ~val;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
